// File: rtl/dot_mac.sv
// dot_mac -- pipelined signed Q8.8 multiply-accumulate (dot product) engine.
//
// Three-stage pipeline, one command per clock, no back-pressure:
//   S1 capture operands + command tag, S2 product (Q16.16 -> Q16.8),
//   S3 accumulate / clear / hold.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   A, B         Q8.8 signed operands, sampled when wrAddr == 1
//   wrAddr       command: 0 idle, 1 sample, 2 clear, 3-15 idle
//   result       registered Q8.8 result
//   result_valid one-cycle pulse when a sample updates result
//   count        samples since last clear, saturating
//   overflow     sticky range violation since last clear
//
// Build option: define DOT_MAC_SAT_EN to saturate result to signed DATA_W
// (saturation also sets overflow); otherwise result is acc truncated.
module dot_mac #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [3:0]        wrAddr,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic [CNT_W-1:0]  count,
  output logic              overflow
);

  // product is computed wide enough for both the full product and the acc
  localparam int PW = (2*DATA_W > ACC_W) ? 2*DATA_W : ACC_W;

  typedef struct packed {
    logic smp;
    logic clr;
  } tag_t;

  tag_t               s1_tag, s2_tag;
  logic [DATA_W-1:0]  a_q, b_q;
  logic [ACC_W-1:0]   prod_q;
  logic [ACC_W-1:0]   acc;

  // ---------------- stage 1: capture ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_tag <= '0;
      a_q    <= '0;
      b_q    <= '0;
    end else begin
      s1_tag.smp <= (wrAddr == 4'd1);
      s1_tag.clr <= (wrAddr == 4'd2);
      if (wrAddr == 4'd1 || wrAddr == 4'd2) begin
        a_q <= A;
        b_q <= B;
      end
    end
  end

  // ---------------- stage 2: multiply + rescale ----------------
  logic signed [PW-1:0] a_ext, b_ext, prod_ext;
  assign a_ext    = PW'($signed(a_q));
  assign b_ext    = PW'($signed(b_q));
  assign prod_ext = a_ext * b_ext;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_tag <= '0;
      prod_q <= '0;
    end else begin
      s2_tag <= s1_tag;
      // arithmetic shift floors toward -inf; cast drops to Q16.8 acc width
      prod_q <= ACC_W'(prod_ext >>> FRAC_W);
    end
  end

  // ---------------- stage 3: accumulate ----------------
  logic [ACC_W:0]     sum_w;
  logic [ACC_W-1:0]   acc_nxt;
  logic               acc_wrap;
  logic [DATA_W-1:0]  res_nxt;
  logic               ovf_evt;

  // one guard bit: signed overflow when the top two bits disagree
  assign sum_w    = {acc[ACC_W-1], acc} + {prod_q[ACC_W-1], prod_q};
  assign acc_nxt  = sum_w[ACC_W-1:0];
  assign acc_wrap = sum_w[ACC_W] ^ sum_w[ACC_W-1];

`ifdef DOT_MAC_SAT_EN
  logic sat_hi, sat_lo;
  // out of DATA_W range iff bits above the result sign bit are not all sign
  assign sat_hi = ~acc_nxt[ACC_W-1] &  (|acc_nxt[ACC_W-2:DATA_W-1]);
  assign sat_lo =  acc_nxt[ACC_W-1] & ~(&acc_nxt[ACC_W-2:DATA_W-1]);

  always_comb begin
    res_nxt = acc_nxt[DATA_W-1:0];
    if (sat_hi)      res_nxt = {1'b0, {(DATA_W-1){1'b1}}};
    else if (sat_lo) res_nxt = {1'b1, {(DATA_W-1){1'b0}}};
  end
  assign ovf_evt = acc_wrap | sat_hi | sat_lo;
`else
  assign res_nxt = acc_nxt[DATA_W-1:0];
  assign ovf_evt = acc_wrap;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      count        <= '0;
      overflow     <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (s2_tag.clr) begin
        acc      <= '0;
        result   <= '0;
        count    <= '0;
        overflow <= 1'b0;
      end else if (s2_tag.smp) begin
        acc          <= acc_nxt;
        result       <= res_nxt;
        result_valid <= 1'b1;
        if (count != '1) count <= count + 1'b1;
        if (ovf_evt)     overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dot_mac.sv
// tb_dot_mac -- self-checking bench for dot_mac.
// Drives commands on the falling edge, checks every output each cycle
// against an arithmetic reference model, plus directed end-point checks.
module tb_dot_mac;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] A, B;
  logic [3:0]  wrAddr;
  logic [15:0] result;
  logic        result_valid;
  logic [7:0]  count;
  logic        overflow;

  dot_mac dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .wrAddr(wrAddr),
    .result(result), .result_valid(result_valid), .count(count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  int npulse = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          cmd;
    logic [15:0] a;
    logic [15:0] b;
    int          due;
  } cmd_t;

  cmd_t        pend[$];
  longint      m_acc;
  logic [15:0] m_res;
  int          m_cnt;
  bit          m_ovf;
  bit          m_vld;

  function automatic longint qmul(input logic [15:0] a, input logic [15:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    // floor(p / 256)
    if (p >= 0) return p / 256;
    else        return -((-p + 255) / 256);
  endfunction

  task automatic mreset();
    pend.delete();
    m_acc = 0; m_res = 0; m_cnt = 0; m_ovf = 0; m_vld = 0;
  endtask

  task automatic mapply(input cmd_t c);
    longint s;
    m_vld = 0;
    if (c.cmd == 2) begin
      m_acc = 0; m_res = 0; m_cnt = 0; m_ovf = 0;
    end else if (c.cmd == 1) begin
      s = m_acc + qmul(c.a, c.b);
      if (s > 64'sd8388607)       begin s = s - 64'sd16777216; m_ovf = 1; end
      else if (s < -64'sd8388608) begin s = s + 64'sd16777216; m_ovf = 1; end
      m_acc = s;
`ifdef DOT_MAC_SAT_EN
      if (m_acc > 32767)       begin m_res = 16'h7FFF; m_ovf = 1; end
      else if (m_acc < -32768) begin m_res = 16'h8000; m_ovf = 1; end
      else                     m_res = 16'(m_acc);
`else
      m_res = 16'(m_acc);
`endif
      if (m_cnt < 255) m_cnt++;
      m_vld = 1;
    end
  endtask

  // one clock: drive at negedge, model at posedge, check at next negedge
  task automatic tick(input int cmd, input logic [15:0] a, input logic [15:0] b);
    cmd_t c;
    wrAddr = 4'(cmd); A = a; B = b;
    @(posedge clk);
    cyc++;
    m_vld = 0;
    if (pend.size() > 0 && pend[0].due == cyc) mapply(pend.pop_front());
    c.cmd = cmd; c.a = a; c.b = b; c.due = cyc + 2;
    pend.push_back(c);
    @(negedge clk);
    if (result_valid) npulse++;
    chk("result", 32'(result), 32'(m_res));
    chk("valid", 32'(result_valid), 32'(m_vld));
    chk("count", 32'(count), 32'(m_cnt));
    chk("ovf", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 16'h0, 16'h0);
  endtask

  logic [15:0] va[10] = '{16'h0140, 16'h0280, 16'h0280, 16'h0200, 16'h0300,
                          16'h0200, 16'h0140, 16'h0380, 16'h0480, 16'h0200};
  logic [15:0] vb[10] = '{16'h0180, 16'h0180, 16'h0500, 16'h0200, 16'h0500,
                          16'h0300, 16'h0380, 16'h0500, 16'h0400, 16'h0300};

  initial begin
    reset = 1'b1; wrAddr = 4'd0; A = '0; B = '0;
    mreset();
    // reset state
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_result", 32'(result), 32'h0);
      chk("rst_valid", 32'(result_valid), 32'h0);
      chk("rst_count", 32'(count), 32'h0);
      chk("rst_ovf", 32'(overflow), 32'h0);
    end
    reset = 1'b0;

    // gapped stream: 1.875+3.75+12.5+4+15+6+4.375+17.5+18+6 = 89.0
    tick(2, 16'h0, 16'h0);
    npulse = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1, va[i], vb[i]);
      idle(62);
    end
    chk("gap_pulses", 32'(npulse), 32'd10);
    chk("gap_result", 32'(result), 32'h5900);
    chk("gap_count", 32'(count), 32'd10);
    chk("gap_ovf", 32'(overflow), 32'h0);

    // back-to-back stream
    tick(2, 16'h0, 16'h0);
    for (int i = 0; i < 10; i++) tick(1, va[i], vb[i]);
    idle(2);
    chk("b2b_result", 32'(result), 32'h5900);
    chk("b2b_count", 32'(count), 32'd10);

    // clear between samples 5 and 6: 6+4.375+17.5+18+6 = 51.875 = 0x33E0
    tick(2, 16'h0, 16'h0);
    for (int i = 0; i < 5; i++) tick(1, va[i], vb[i]);
    tick(2, 16'h0, 16'h0);
    for (int i = 5; i < 10; i++) tick(1, va[i], vb[i]);
    idle(2);
    chk("mid_clr_result", 32'(result), 32'h33E0);
    chk("mid_clr_count", 32'(count), 32'd5);

    // negative product: -1.0 * 2.5
    tick(2, 16'h0, 16'h0);
    tick(1, 16'hFF00, 16'h0280);
    idle(2);
    chk("neg_result", 32'(result), 32'hFD80);
    chk("neg_ovf", 32'(overflow), 32'h0);

    // 127 * 127 = 16129: out of Q8.8 range
    tick(2, 16'h0, 16'h0);
    tick(1, 16'h7F00, 16'h7F00);
    idle(2);
`ifdef DOT_MAC_SAT_EN
    chk("big_result", 32'(result), 32'h7FFF);
    chk("big_ovf", 32'(overflow), 32'h1);
`else
    chk("big_result", 32'(result), 32'h0100);
    chk("big_ovf", 32'(overflow), 32'h0);
`endif
    tick(2, 16'h0, 16'h0);
    idle(2);
    chk("clr_result", 32'(result), 32'h0);
    chk("clr_ovf", 32'(overflow), 32'h0);

    // back-to-back clears
    tick(2, 16'h0, 16'h0);
    tick(2, 16'h0, 16'h0);
    tick(1, 16'h0100, 16'h0100);
    idle(2);

    // random full-range samples, no clears: count saturates, acc wraps
    tick(2, 16'h0, 16'h0);
    for (int i = 0; i < 280; i++) tick(1, 16'($urandom), 16'($urandom));
    idle(2);
    chk("cnt_sat", 32'(count), 32'hFF);

    // random mix of all command codes
    for (int i = 0; i < 400; i++) begin
      int r, cmd;
      r = $urandom_range(0, 99);
      if (r < 60)      cmd = 1;
      else if (r < 64) cmd = 2;
      else if (r < 80) cmd = 0;
      else             cmd = $urandom_range(3, 15);
      tick(cmd, 16'($urandom_range(0, 16'h0FFF)) - 16'h0800, 16'($urandom));
    end
    idle(2);

    // async reset with two samples in flight
    tick(2, 16'h0, 16'h0);
    for (int i = 0; i < 3; i++) tick(1, va[i], vb[i]);
    idle(2);
    tick(1, va[3], vb[3]);
    tick(1, va[4], vb[4]);
    #2 reset = 1'b1;
    #1;
    chk("arst_result", 32'(result), 32'h0);
    chk("arst_valid", 32'(result_valid), 32'h0);
    chk("arst_count", 32'(count), 32'h0);
    chk("arst_ovf", 32'(overflow), 32'h0);
    mreset();
    @(negedge clk);
    reset = 1'b0;
    npulse = 0;
    idle(6);
    chk("arst_pulses", 32'(npulse), 32'd0);
    chk("arst_count_after", 32'(count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
